var_bitreverse: RTL and testbench

Run-time-sized bit-reversal reorder buffer for the pipelined FFT output, the next generation of the fixed-size bit-reverse stage. It accepts natural-order FFT output one complex sample per `i_ce` and emits each frame in bit-reversed order. It uses a ping-pong memory sized for the largest transform. Frame size is selectable per frame from 2 to 2^MAXLG points, and an explicit output-valid flag marks primed data.

---
 rtl/var_bitreverse.sv | 140 ++++++++++++++
 tb/tb_var_bitreverse.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/var_bitreverse.sv
`default_nettype none
// ============================================================================
//  Module   : var_bitreverse
//  Purpose  : Run-time-sized bit-reversal reorder buffer for a pipelined FFT.
//             Accepts natural-order samples one per i_ce and emits each frame
//             in bit-reversed order through a ping-pong memory sized for the
//             largest transform (2 * 2^MAXLG words).
//  Ports    : i_clk     - sole clock, rising edge
//             i_reset   - synchronous, active-high reset
//             i_ce      - sample strobe; all state advances only when high
//             i_lgsize  - requested log2 frame size, clamped to [1, MAXLG],
//                         sampled at frame boundaries
//             i_sync    - first-sample marker (VARBITREV_INSYNC_EN only)
//             i_in      - natural-order sample {real, imag}
//             o_out     - bit-reversed sample
//             o_sync    - high with index 0 of each valid output frame
//             o_valid   - high while o_out carries a completely written frame
//  Options  : `define VARBITREV_INSYNC_EN to let i_sync realign the write side
//  Revision : 1.0 - initial release
// ============================================================================
module var_bitreverse #(
    parameter int MAXLG = 10,
    parameter int WIDTH = 24,
    parameter int LGW   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce,
    input  logic [LGW-1:0]       i_lgsize,
    input  logic                 i_sync,
    input  logic [2*WIDTH-1:0]   i_in,
    output logic [2*WIDTH-1:0]   o_out,
    output logic                 o_sync,
    output logic                 o_valid
);

    localparam int             c_depth = 2 * (2 ** MAXLG);
    localparam logic [MAXLG-1:0] c_ones = '1;

    logic [2*WIDTH-1:0] r_mem [0:c_depth-1];

    logic [LGW-1:0]   r_lg;
    logic [MAXLG-1:0] r_cnt;
    logic             r_bank;
    logic             r_primed;

    logic [LGW-1:0]   w_lg_req;
    logic [MAXLG-1:0] w_last_idx;
    logic [MAXLG-1:0] w_rev_full;
    logic [MAXLG-1:0] w_rev;
    logic             w_last;
    logic             w_realign;
    logic [MAXLG:0]   w_wraddr;
    logic [MAXLG:0]   w_rdaddr;

    // Requested size clamped into the supported range [1, MAXLG].
    always_comb begin
        w_lg_req = i_lgsize;
        if (i_lgsize == '0) begin
            w_lg_req = LGW'(1);
        end else if (i_lgsize > LGW'(MAXLG)) begin
            w_lg_req = LGW'(MAXLG);
        end
    end

    // Last index of the current frame: 2^lg - 1 as a right-shifted mask.
    assign w_last_idx = c_ones >> (LGW'(MAXLG) - r_lg);
    assign w_last     = (r_cnt == w_last_idx);

    // Reverse all MAXLG bits, then shift down so only the low lg bits of the
    // counter land (reversed) in the low lg bits; upper bits become zero.
    always_comb begin
        w_rev_full = '0;
        for (int b = 0; b < MAXLG; b++) begin
            w_rev_full[b] = r_cnt[MAXLG-1-b];
        end
    end
    assign w_rev = w_rev_full >> (LGW'(MAXLG) - r_lg);

`ifdef VARBITREV_INSYNC_EN
    // A sync strobe anywhere but index 0 restarts the frame in the other bank.
    assign w_realign = i_sync && (r_cnt != '0);
`else
    logic w_unused_sync;
    assign w_unused_sync = i_sync;
    assign w_realign     = 1'b0;
`endif

    // On realign the sample goes to index 0 of the bank we are about to
    // switch into, so the write never collides with the pending read.
    assign w_wraddr = w_realign ? {~r_bank, {MAXLG{1'b0}}} : {r_bank, r_cnt};
    assign w_rdaddr = {~r_bank, w_rev};

    // Write-side counter, bank select, size register and priming flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_bank   <= 1'b0;
            r_lg     <= w_lg_req;
            r_primed <= 1'b0;
        end else if (i_ce) begin
            if (w_realign) begin
                r_cnt    <= MAXLG'(1);
                r_bank   <= ~r_bank;
                r_lg     <= w_lg_req;
                r_primed <= 1'b0;
            end else if (w_last) begin
                r_cnt    <= '0;
                r_bank   <= ~r_bank;
                r_lg     <= w_lg_req;
                // A size change discards the frame just written.
                r_primed <= (w_lg_req == r_lg);
            end else begin
                r_cnt    <= r_cnt + MAXLG'(1);
            end
        end
    end

    // Memory write port (contents are never reset).
    always_ff @(posedge i_clk) begin
        if (i_ce && !i_reset) begin
            r_mem[w_wraddr] <= i_in;
        end
    end

    // Registered read port and output flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_out   <= '0;
            o_sync  <= 1'b0;
            o_valid <= 1'b0;
        end else if (i_ce) begin
            o_out   <= r_mem[w_rdaddr];
            o_valid <= r_primed;
            o_sync  <= r_primed && (r_cnt == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_var_bitreverse.sv
`default_nettype none
// ============================================================================
//  Module   : tb_var_bitreverse
//  Purpose  : Self-checking bench for var_bitreverse (MAXLG=4). A frame-level
//             reference model (arrays of whole frames, arithmetic bit reversal)
//             predicts o_out/o_sync/o_valid; directed tables and sequences
//             cover reorder, i_ce gaps, size change, clamping and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_var_bitreverse;

    localparam int MAXLG = 4;
    localparam int WIDTH = 8;
    localparam int LGW   = 4;
    localparam int SW    = 2 * WIDTH;
    localparam int NMAX  = 1 << MAXLG;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_ce;
    logic [LGW-1:0] i_lgsize;
    logic          i_sync;
    logic [SW-1:0] i_in;
    logic [SW-1:0] o_out;
    logic          o_sync;
    logic          o_valid;

    var_bitreverse #(.MAXLG(MAXLG), .WIDTH(WIDTH), .LGW(LGW)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .i_lgsize(i_lgsize),
        .i_sync  (i_sync),
        .i_in    (i_in),
        .o_out   (o_out),
        .o_sync  (o_sync),
        .o_valid (o_valid)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // ---------------- frame-level reference model ----------------
    int            m_lg;
    int            m_j;
    bit            m_prev_ok;
    logic [SW-1:0] m_cur  [NMAX];
    logic [SW-1:0] m_prev [NMAX];
    logic [SW-1:0] e_out;
    logic          e_valid;
    logic          e_sync;
    bit            e_out_known;

    function automatic int clampf(int v);
        if (v < 1) return 1;
        if (v > MAXLG) return MAXLG;
        return v;
    endfunction

    function automatic int revf(int j, int n);
        int r = 0;
        for (int b = 0; b < n; b++) begin
            if (((j >> b) & 1) != 0) r = r + (1 << (n - 1 - b));
        end
        return r;
    endfunction

    function automatic void model_reset(int lgs);
        m_lg        = clampf(lgs);
        m_j         = 0;
        m_prev_ok   = 1'b0;
        e_out       = '0;
        e_valid     = 1'b0;
        e_sync      = 1'b0;
        e_out_known = 1'b1;
    endfunction

    function automatic void model_strobe(int lgs, logic sync, logic [SW-1:0] din);
        int n;
        e_valid     = m_prev_ok;
        e_sync      = m_prev_ok && (m_j == 0);
        e_out_known = m_prev_ok;
        if (m_prev_ok) e_out = m_prev[revf(m_j, m_lg)];
`ifdef VARBITREV_INSYNC_EN
        if (sync && m_j != 0) begin
            e_sync    = 1'b0;
            m_prev    = m_cur;
            m_prev_ok = 1'b0;
            m_lg      = clampf(lgs);
            m_cur[0]  = din;
            m_j       = 1;
            return;
        end
`endif
        m_cur[m_j] = din;
        m_j = m_j + 1;
        if (m_j == (1 << m_lg)) begin
            n         = clampf(lgs);
            m_prev    = m_cur;
            m_prev_ok = (n == m_lg);
            m_lg      = n;
            m_j       = 0;
        end
    endfunction

    // ---------------- checking and driving ----------------
    task automatic chk(string name, logic [SW-1:0] act, logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(logic ce, int lgs, logic sync, logic [SW-1:0] din);
        i_ce     = ce;
        i_lgsize = LGW'(lgs);
        i_sync   = sync;
        i_in     = din;
        @(posedge i_clk);
        #1;
        if (ce) model_strobe(lgs, sync, din);
        chk("valid", SW'(o_valid), SW'(e_valid));
        chk("sync", SW'(o_sync), SW'(e_sync));
        if (e_out_known) chk("out", o_out, e_out);
    endtask

    task automatic do_reset(logic ce, int lgs);
        i_reset  = 1'b1;
        i_ce     = ce;
        i_sync   = 1'b0;
        i_lgsize = LGW'(lgs);
        i_in     = SW'($urandom);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        i_ce    = 1'b0;
        model_reset(lgs);
        chk("rst_valid", SW'(o_valid), '0);
        chk("rst_sync", SW'(o_sync), '0);
        chk("rst_out", o_out, '0);
    endtask

    typedef struct {
        logic [SW-1:0] din;
        logic          ev;
        logic          es;
        logic [SW-1:0] eo;
    } vec_t;

    vec_t tbl [16];
    int   rev8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int   p4   [4] = '{0, 2, 1, 3};

    initial begin
        int lgs;
        int k;

        i_reset = 1'b0; i_ce = 1'b0; i_sync = 1'b0; i_lgsize = '0; i_in = '0;

        // Basic reorder table: frame 0 = 0..7, frame 1 outputs it reversed.
        for (int i = 0; i < 16; i++) begin
            tbl[i].din = SW'(i);
            tbl[i].ev  = (i >= 8);
            tbl[i].es  = (i == 8);
            tbl[i].eo  = (i >= 8) ? SW'(rev8[i-8]) : '0;
        end
        do_reset(1'b0, 3);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 3, 1'b0, tbl[i].din);
            chk("tbl_valid", SW'(o_valid), SW'(tbl[i].ev));
            chk("tbl_sync", SW'(o_sync), SW'(tbl[i].es));
            if (tbl[i].ev) chk("tbl_out", o_out, tbl[i].eo);
        end

        // i_ce gaps: 1,0,0 pattern; outputs hold while i_ce is low.
        do_reset(1'b0, 3);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 3, 1'b0, SW'(i));
            step(1'b0, 3, 1'b0, SW'(i + 100));
            step(1'b0, 3, 1'b0, SW'(i + 200));
            if (i >= 8) chk("gap_out", o_out, SW'(rev8[i-8]));
        end

        // Size change 3 -> 2 at the end of frame 1.
        do_reset(1'b0, 3);
        for (int i = 0; i < 16; i++) step(1'b1, (i == 15) ? 2 : 3, 1'b0, SW'(i));
        for (int i = 16; i < 20; i++) begin
            step(1'b1, 2, 1'b0, SW'(i));
            chk("sz_gap_valid", SW'(o_valid), '0);
        end
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 4; j++) begin
                step(1'b1, 2, 1'b0, SW'(20 + 4*f + j));
                chk("sz_out", o_out, SW'(16 + 4*f + p4[j]));
                chk("sz_sync", SW'(o_sync), SW'(j == 0));
            end
        end

        // Clamp low: lgsize 0 behaves as frames of 2.
        do_reset(1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 0, 1'b0, SW'(i));
            if (i == 2) begin
                chk("clamp0_out0", o_out, SW'(0));
                chk("clamp0_sync", SW'(o_sync), SW'(1));
            end
            if (i == 3) chk("clamp0_out1", o_out, SW'(1));
        end

        // Clamp high: lgsize 15 behaves as frames of 16.
        do_reset(1'b0, 15);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 15, 1'b0, SW'(i));
            if (i == 15) chk("clamp15_nvalid", SW'(o_valid), '0);
            if (i == 16) chk("clamp15_sync", SW'(o_sync), SW'(1));
            if (i == 17) chk("clamp15_out", o_out, SW'(8));
        end

        // Reset mid-frame (cnt = 5), with i_ce high during reset.
        do_reset(1'b0, 3);
        for (int i = 0; i < 13; i++) step(1'b1, 3, 1'b0, SW'(i));
        do_reset(1'b1, 3);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3, 1'b0, SW'(50 + i));
            chk("midrst_valid", SW'(o_valid), '0);
        end
        step(1'b1, 3, 1'b0, SW'(58));
        chk("midrst_sync", SW'(o_sync), SW'(1));
        chk("midrst_out", o_out, SW'(50));

`ifdef VARBITREV_INSYNC_EN
        // Realign at cnt = 3.
        do_reset(1'b0, 3);
        for (int i = 0; i < 3; i++) step(1'b1, 3, 1'b0, SW'(60 + i));
        step(1'b1, 3, 1'b1, SW'(77));
        chk("realign_valid", SW'(o_valid), '0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 3, 1'b0, SW'(80 + i));
            chk("realign_low", SW'(o_valid), '0);
        end
        step(1'b1, 3, 1'b0, SW'(90));
        chk("realign_sync", SW'(o_sync), SW'(1));
        chk("realign_out", o_out, SW'(77));
`endif

        // Randomized traffic against the model.
        do_reset(1'b0, 3);
        lgs = 3;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 79) == 0) lgs = $urandom_range(0, 15);
            k = $urandom_range(0, 399);
            if (k == 0) do_reset(1'b1, lgs);
            else step($urandom_range(0, 3) != 0, lgs, $urandom_range(0, 31) == 0, SW'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
